uart_tx_core: RTL
=================

UART_TX_CORE -- requirements
Module: uart_tx_core

Interface
REQ-001 Parameter CLK_PER_BIT, default 5208, clock cycles per UART bit (50 MHz / 9600 baud); legal range >= 2.
REQ-002 Parameter DATA_WIDTH, default 8, payload bits per frame; legal range 5..9.
REQ-003 Parameter PARITY_EN, default 0, 1 = append parity bit after payload.
REQ-004 Parameter PARITY_ODD, default 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0.
REQ-005 Parameter STOP_BITS, default 1, stop bits per frame; legal values 1, 2.
REQ-006 clk  input  1  single system clock; all logic on rising edge.
REQ-007 rst  input  1  asynchronous, active-low reset.
REQ-008 tx_data  input  DATA_WIDTH  payload; sampled only on accept.
REQ-009 tx_valid  input  1  payload request.
REQ-010 tx_ready  output  1  block can accept a payload this cycle.
REQ-011 tx_out  output  1  serial line; idle level 1.
REQ-012 tx_busy  output  1  frame in progress (start through last stop bit).
REQ-013 tx_done  output  1  one-cycle pulse at frame completion.

Function
REQ-014 FSM states IDLE, START, DATA, PARITY, STOP; PARITY is skipped when PARITY_EN=0.
REQ-015 tx_ready = 1 only in IDLE; accept = tx_valid & tx_ready; tx_data is copied into an internal shift register on accept.
REQ-016 The cycle after accept, state = START and tx_out = 0; tx_valid and tx_data during a frame are ignored and do not affect the frame.
REQ-017 Each bit (start, data, parity, each stop) drives tx_out for exactly CLK_PER_BIT cycles, timed by a bit counter of width $clog2(CLK_PER_BIT) counting 0..CLK_PER_BIT-1 and cleared on every bit boundary.
REQ-018 Data bits are sent LSB first; a data-bit index counts 0..DATA_WIDTH-1 and DATA exits after index DATA_WIDTH-1 completes.
REQ-019 Parity bit = XOR of the captured payload when PARITY_ODD=0, inverted XOR when PARITY_ODD=1.
REQ-020 STOP drives tx_out = 1 for STOP_BITS*CLK_PER_BIT cycles; tx_done pulses on the last cycle of the final stop bit, then state = IDLE.
REQ-021 Frame length from accept = 1 + (1 + DATA_WIDTH + PARITY_EN + STOP_BITS)*CLK_PER_BIT cycles to the next possible accept; continuously held tx_valid yields back-to-back frames with exactly one idle-high cycle between them.
REQ-022 tx_busy = 1 in START, DATA, PARITY and STOP; tx_busy = ~tx_ready at all times.
REQ-023 tx_out is registered (glitch-free); in IDLE tx_out = 1.

Reset
REQ-024 rst low asynchronously forces state IDLE, tx_out = 1, tx_ready = 1 (after release), tx_busy = 0, tx_done = 0, all counters and the shift register to 0.
REQ-025 Reset asserted mid-frame aborts the frame immediately with no tx_done pulse; the first accept after release starts a complete new frame.

Structure
REQ-026 A shared package uart_pkg holds the FSM state enumeration and parity mode constants (PARITY_EVEN = 0, PARITY_ODD = 1) for reuse by the future receiver.
REQ-027 The bit-timing counter is a sub-module uart_baud_tick (CLK_PER_BIT parameter; inputs clk, rst, clear, enable; output tick on the last cycle of each bit).
REQ-028 The remaining logic (FSM, shift register, parity, bit index) stays in uart_tx_core; the target size is 120-400 lines of RTL total.

Verification (CLK_PER_BIT=4 unless stated)
REQ-029 8N1, tx_data=0xA5 accepted at cycle 0 -> tx_out sequence 0,1,0,1,0,0,1,0,1,1, each level held 4 cycles, starting at cycle 1; tx_done pulses at cycle 40.
REQ-030 8E1, tx_data=0x07 -> parity bit = 1; 8O1, tx_data=0x07 -> parity bit = 0; frame lasts 44 cycles after the accept cycle.
REQ-031 DATA_WIDTH=5, STOP_BITS=2, tx_data=0x1F -> 0, then 1 x5, then 1 x2; tx_done pulses 32 cycles after the start bit begins.
REQ-032 tx_valid held high with tx_data 0x55 then 0xAA -> second start bit begins exactly 1 idle cycle after the first tx_done; tx_ready is low throughout each frame; tx_data changes mid-frame do not alter the bits sent.
REQ-033 rst asserted during data bit 3 -> tx_out = 1 and tx_busy = 0 in the same cycle with no tx_done pulse; after release, a new 0x3C frame is transmitted intact.
REQ-034 Default parameters, one 0x41 frame -> each bit lasts exactly 5208 cycles, measured by the bench at the tx_out edges.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and parity mode constants,
// common to the transmitter and the future receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam int PARITY_EVEN = 0;
    localparam int PARITY_ODD  = 1;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts 0..CLK_PER_BIT-1 while enabled and flags the
// last cycle of each bit; clear forces the count back to zero.
module uart_baud_tick #(
    parameter int CLK_PER_BIT = 5208
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int               CNT_W = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLK_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = enable && (cnt == LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clear || tick) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_tx_core.sv
// UART transmitter: start bit, LSB-first payload, optional parity and one or
// two stop bits, with a registered serial line output.
module uart_tx_core #(
    parameter int CLK_PER_BIT = 5208,
    parameter int DATA_WIDTH  = 8,
    parameter int PARITY_EN   = 0,
    parameter int PARITY_ODD  = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  tx_out,
    output logic                  tx_busy,
    output logic                  tx_done
);

    import uart_pkg::*;

    localparam int IDX_W = $clog2(DATA_WIDTH);

    uart_state_e           state;
    uart_state_e           next_state;
    logic [DATA_WIDTH-1:0] shreg;
    logic [IDX_W-1:0]      bit_idx;
    logic                  stop_idx;
    logic                  par_bit;
    logic                  tick;
    logic                  accept;
    logic                  last_data;
    logic                  last_stop;
    logic                  baud_en;
    logic                  baud_clr;

    function automatic logic calc_parity(input logic [DATA_WIDTH-1:0] d);
        return (^d) ^ (PARITY_ODD != uart_pkg::PARITY_EVEN);
    endfunction

    uart_baud_tick #(
        .CLK_PER_BIT(CLK_PER_BIT)
    ) u_baud (
        .clk   (clk),
        .rst   (rst),
        .clear (baud_clr),
        .enable(baud_en),
        .tick  (tick)
    );

    assign accept    = tx_valid && tx_ready;
    assign last_data = (bit_idx == IDX_W'(DATA_WIDTH - 1));
    assign last_stop = (stop_idx == 1'(STOP_BITS - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            ST_IDLE:   if (accept) next_state = ST_START;
            ST_START:  if (tick) next_state = ST_DATA;
            ST_DATA:   if (tick && last_data) next_state = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
            ST_PARITY: if (tick) next_state = ST_STOP;
            ST_STOP:   if (tick && last_stop) next_state = ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        tx_ready = (state == ST_IDLE);
        tx_busy  = (state != ST_IDLE);
        tx_done  = (state == ST_STOP) && tick && last_stop;
        baud_en  = (state != ST_IDLE);
        baud_clr = (state == ST_IDLE);
    end

    // The line level for the next bit is loaded on the bit boundary so tx_out
    // changes on the same edge as the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg    <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            par_bit  <= 1'b0;
            tx_out   <= 1'b1;
        end else if (accept) begin
            shreg    <= tx_data;
            par_bit  <= calc_parity(tx_data);
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            tx_out   <= 1'b0;
        end else if (tick) begin
            case (state)
                ST_START: tx_out <= shreg[0];
                ST_DATA: begin
                    if (last_data) begin
                        tx_out <= (PARITY_EN != 0) ? par_bit : 1'b1;
                    end else begin
                        shreg   <= shreg >> 1;
                        bit_idx <= bit_idx + IDX_W'(1);
                        tx_out  <= shreg[1];
                    end
                end
                ST_PARITY: tx_out <= 1'b1;
                ST_STOP: begin
                    tx_out   <= 1'b1;
                    stop_idx <= last_stop ? 1'b0 : 1'b1;
                end
                default: tx_out <= 1'b1;
            endcase
        end
    end

endmodule
